vigna_coproc_issue: RTL and testbench

VIGNA_COPROC_ISSUE -- requirements
Module: vigna_coproc_issue

---
 rtl/vigna_coproc_issue_if.sv | 48 ++++
 rtl/vigna_coproc_issue.sv | 151 +++++++++++++++
 tb/tb_vigna_coproc_issue.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vigna_coproc_issue_if.sv
// vigna_coproc_issue_if
// Bundles the three handshakes of the coprocessor issue unit:
//   core request : req_valid/req_ready carrying req_func, req_rd, req_op1, req_op2, plus flush
//   coprocessor  : cp_valid carrying cp_func, cp_op1, cp_op2; cp_ready is a one-cycle
//                  completion pulse carrying cp_result
//   writeback    : wb_valid/wb_ready carrying wb_rd, wb_data
// Modports:
//   slave  - the issue unit itself
//   master - the surrounding core / coprocessor environment
interface vigna_coproc_issue_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_func;
   logic [4:0]  req_rd;
   logic [31:0] req_op1;
   logic [31:0] req_op2;
   logic        flush;

   logic        cp_valid;
   logic [2:0]  cp_func;
   logic [31:0] cp_op1;
   logic [31:0] cp_op2;
   logic        cp_ready;
   logic [31:0] cp_result;

   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   modport slave (
      input  req_valid, req_func, req_rd, req_op1, req_op2, flush,
      output req_ready,
      output cp_valid, cp_func, cp_op1, cp_op2,
      input  cp_ready, cp_result,
      output wb_valid, wb_rd, wb_data,
      input  wb_ready
   );

   modport master (
      output req_valid, req_func, req_rd, req_op1, req_op2, flush,
      input  req_ready,
      input  cp_valid, cp_func, cp_op1, cp_op2,
      output cp_ready, cp_result,
      input  wb_valid, wb_rd, wb_data,
      output wb_ready
   );
endinterface

// File: rtl/vigna_coproc_issue.sv
// vigna_coproc_issue
// Issues one core operation at a time to a multi-cycle coprocessor and hands the
// result back to the core's writeback port. A flush from the core discards the
// operation; since the coprocessor cannot abort, a flushed operation still waits
// for its completion pulse (DROP) before a new request is taken.
// Ports:
//   clk       - sole clock, rising edge
//   resetn    - asynchronous active-low reset
//   bus       - request / coprocessor / writeback handshakes (slave modport)
//   busy      - high whenever the FSM is not IDLE
//   op_count  - completed (written back) operations, wraps modulo 2^CNT_W
//   dbg_state - current FSM state (0 IDLE, 1 ISSUE, 2 DROP, 3 HOLD)
//
// Handshake semantics: a request transfers on a rising edge where req_valid and
// req_ready are both high; a result transfers on a rising edge where wb_valid and
// wb_ready are both high. cp_valid, wb_valid and their payloads are registered
// and do not depend combinationally on any input; req_ready depends only on the
// state and flush. cp_ready is a completion pulse, not a ready: it is sampled
// only in ISSUE and DROP.
module vigna_coproc_issue #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             resetn,
   vigna_coproc_issue_if.slave bus,
   output logic             busy,
   output logic [CNT_W-1:0] op_count,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DROP  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [2:0]       cp_func_q;
   logic [31:0]      cp_op1_q;
   logic [31:0]      cp_op2_q;
   logic [4:0]       wb_rd_q;
   logic [31:0]      wb_data_q;
   logic [CNT_W-1:0] op_count_q;

   logic accept;
   logic capture;
   logic commit;

   // flush in IDLE blocks acceptance; a flush arriving with cp_ready in ISSUE
   // turns the completion into a drop; a flush in HOLD beats wb_ready.
   assign accept  = (state == S_IDLE)  && bus.req_valid && !bus.flush;
   assign capture = (state == S_ISSUE) && bus.cp_ready  && !bus.flush;
   assign commit  = (state == S_HOLD)  && bus.wb_ready  && !bus.flush;

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (bus.req_valid && !bus.flush) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            if (bus.cp_ready) begin
               state_nxt = bus.flush ? S_IDLE : S_HOLD;
            end else if (bus.flush) begin
               state_nxt = S_DROP;
            end
         end
         S_DROP: begin
            if (bus.cp_ready) state_nxt = S_IDLE;
         end
         S_HOLD: begin
            if (bus.flush || bus.wb_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic: strobes decode straight from the state register, so cp_valid
   // drops on the completion edge and every path back to an op passes through
   // at least one IDLE cycle with cp_valid low.
   always_comb begin
      bus.req_ready = 1'b0;
      bus.cp_valid  = 1'b0;
      bus.wb_valid  = 1'b0;
      busy          = 1'b1;
      case (state)
         S_IDLE: begin
            bus.req_ready = !bus.flush;
            busy          = 1'b0;
         end
         S_ISSUE, S_DROP: begin
            bus.cp_valid = 1'b1;
         end
         S_HOLD: begin
            bus.wb_valid = 1'b1;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   // Datapath: operands and rd are latched once at acceptance and stay put
   // through ISSUE/DROP/HOLD, which keeps cp_* stable while the coprocessor
   // computes and wb_rd stable while the result waits for wb_ready.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cp_func_q  <= 3'd0;
         cp_op1_q   <= 32'd0;
         cp_op2_q   <= 32'd0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= 32'd0;
         op_count_q <= '0;
      end else begin
         if (accept) begin
            cp_func_q <= bus.req_func;
            cp_op1_q  <= bus.req_op1;
            cp_op2_q  <= bus.req_op2;
            wb_rd_q   <= bus.req_rd;
         end
         if (capture) begin
            wb_data_q <= bus.cp_result;
         end
         if (commit) begin
            op_count_q <= op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign bus.cp_func = cp_func_q;
   assign bus.cp_op1  = cp_op1_q;
   assign bus.cp_op2  = cp_op2_q;
   assign bus.wb_rd   = wb_rd_q;
   assign bus.wb_data = wb_data_q;
   assign op_count    = op_count_q;
   assign dbg_state   = state;

endmodule

// File: tb/tb_vigna_coproc_issue.sv
// tb_vigna_coproc_issue
// Drives randomized and directed operations into vigna_coproc_issue, with a
// behavioural coprocessor (programmable latency) and a writeback monitor that
// pops expected {rd, data} entries from a queue filled at issue time.
module tb_vigna_coproc_issue;
   localparam int CNT_W   = 4;
   localparam int CNT_MOD = 1 << CNT_W;

   logic             clk;
   logic             resetn;
   logic             busy;
   logic [CNT_W-1:0] op_count;
   logic [1:0]       dbg_state;

   vigna_coproc_issue_if bus();

   vigna_coproc_issue #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (bus),
      .busy      (busy),
      .op_count  (op_count),
      .dbg_state (dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [36:0] exp_q[$];
   int          exp_count = 0;
   int          cp_lat    = 1;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   task automatic note_timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got timeout, expected DUT event at %0t", name, $time);
   endtask

   // Architectural result of each coprocessor function (RISC-V M semantics).
   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa;
      longint      sb;
      longint      ub;
      logic [63:0] p;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'd0, b});
      p  = 64'd0;
      r  = 32'd0;
      case (f)
         3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
         3'd4: begin
            if (b == 32'd0) r = 32'hffff_ffff;
            else begin p = sa / sb; r = p[31:0]; end
         end
         3'd5: r = (b == 32'd0) ? 32'hffff_ffff : a / b;
         3'd6: begin
            if (b == 32'd0) r = a;
            else begin p = sa % sb; r = p[31:0]; end
         end
         default: r = (b == 32'd0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] pick_op();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hffff_ffff;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- coprocessor model ----------------
   logic [2:0]  cpm_func;
   logic [31:0] cpm_op1;
   logic [31:0] cpm_op2;
   int          cpm_cnt;
   bit          cpm_busy;
   bit          cpm_done_prev;

   initial begin
      bus.cp_ready  = 1'b0;
      bus.cp_result = 32'd0;
      cpm_busy      = 1'b0;
      cpm_done_prev = 1'b0;
      cpm_cnt       = 0;
      forever begin
         @(posedge clk);
         #1;
         bus.cp_ready = 1'b0;
         if (!resetn) begin
            cpm_busy      = 1'b0;
            cpm_done_prev = 1'b0;
         end else begin
            if (cpm_done_prev) check("cp_valid_gap", 32'(bus.cp_valid), 32'd0);
            cpm_done_prev = 1'b0;
            if (!cpm_busy && bus.cp_valid) begin
               cpm_busy = 1'b1;
               cpm_func = bus.cp_func;
               cpm_op1  = bus.cp_op1;
               cpm_op2  = bus.cp_op2;
               cpm_cnt  = cp_lat;
            end
            if (cpm_busy) begin
               cpm_cnt--;
               if (cpm_cnt <= 0) begin
                  check("cp_valid_held", 32'(bus.cp_valid), 32'd1);
                  check("cp_func_held", 32'(bus.cp_func), 32'(cpm_func));
                  check("cp_op1_held", bus.cp_op1, cpm_op1);
                  check("cp_op2_held", bus.cp_op2, cpm_op2);
                  bus.cp_ready  = 1'b1;
                  bus.cp_result = ref_result(cpm_func, cpm_op1, cpm_op2);
                  cpm_busy      = 1'b0;
                  cpm_done_prev = 1'b1;
               end
            end
         end
      end
   end

   // ---------------- writeback monitor / scoreboard ----------------
   initial begin
      logic [36:0] e;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            exp_count = 0;
         end else begin
            check("op_count", 32'(op_count), 32'(exp_count));
            if (bus.wb_valid) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_wb: got wb_valid=1 rd=%0d data=0x%08h, expected no writeback at %0t",
                           bus.wb_rd, bus.wb_data, $time);
               end else begin
                  e = exp_q[0];
                  check("wb_rd", 32'(bus.wb_rd), 32'(e[36:32]));
                  check("wb_data", bus.wb_data, e[31:0]);
                  if (bus.flush || bus.wb_ready) begin
                     void'(exp_q.pop_front());
                     if (bus.wb_ready && !bus.flush) exp_count = (exp_count + 1) % CNT_MOD;
                  end
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_wb(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.wb_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) note_timeout("wait_wb_valid");
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) note_timeout("wait_idle");
   endtask

   // mode 0: normal, hold = cycles wb_ready stays low after wb_valid
   // mode 1: flush while ISSUE, hold = accept-relative cycle of the flush (lat > hold+1)
   // mode 2: flush on the same edge as cp_ready
   // mode 3: flush in HOLD together with wb_ready
   // mode 4: asynchronous reset a few cycles into ISSUE
   task automatic run_op(input logic [2:0] f, input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] b, input int mode, input int lat, input int hold);
      bit got;
      bit ok;
      cp_lat = lat;
      if (mode == 0 || mode == 3) exp_q.push_back({rd, ref_result(f, a, b)});
      bus.req_func  = f;
      bus.req_rd    = rd;
      bus.req_op1   = a;
      bus.req_op2   = b;
      bus.req_valid = 1'b1;
      bus.wb_ready  = (mode == 0 && hold == 0);
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (bus.req_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!got) begin
         bus.req_valid = 1'b0;
         note_timeout("req_accept");
         return;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      case (mode)
         0: begin
            wait_wb(ok);
            if (hold > 0) begin
               repeat (hold) @(posedge clk);
               #1;
               bus.wb_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.wb_ready = 1'b0;
         end
         1: begin
            repeat (hold) @(posedge clk);
            #1;
            bus.flush = 1'b1;
            @(posedge clk);
            #1;
            bus.flush = 1'b0;
         end
         2: begin
            repeat (lat - 1) @(posedge clk);
            #1;
            bus.flush = 1'b1;
            @(posedge clk);
            #1;
            bus.flush = 1'b0;
         end
         3: begin
            wait_wb(ok);
            @(posedge clk);
            #1;
            bus.flush    = 1'b1;
            bus.wb_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.flush    = 1'b0;
            bus.wb_ready = 1'b0;
         end
         default: begin
            repeat (3) @(posedge clk);
            #3;
            resetn = 1'b0;
            #1;
            check("rst_cp_valid", 32'(bus.cp_valid), 32'd0);
            check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_cp_op1", bus.cp_op1, 32'd0);
            check("rst_cp_op2", bus.cp_op2, 32'd0);
            check("rst_cp_func", 32'(bus.cp_func), 32'd0);
            check("rst_wb_data", bus.wb_data, 32'd0);
            check("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
            check("rst_op_count", 32'(op_count), 32'd0);
            @(negedge clk);
            @(negedge clk);
            #2;
            resetn = 1'b1;
         end
      endcase
      wait_idle();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: got no end of stimulus, expected completion by %0t", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // ---------------- main stimulus ----------------
   initial begin
      int mode;
      int lat;
      int hold;
      resetn        = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_func  = 3'd0;
      bus.req_rd    = 5'd0;
      bus.req_op1   = 32'd0;
      bus.req_op2   = 32'd0;
      bus.flush     = 1'b0;
      bus.wb_ready  = 1'b0;

      #3;
      check("init_cp_valid", 32'(bus.cp_valid), 32'd0);
      check("init_wb_valid", 32'(bus.wb_valid), 32'd0);
      check("init_busy", 32'(busy), 32'd0);
      check("init_op_count", 32'(op_count), 32'd0);
      check("init_wb_data", bus.wb_data, 32'd0);
      check("init_wb_rd", 32'(bus.wb_rd), 32'd0);
      check("init_cp_op1", bus.cp_op1, 32'd0);
      check("init_state", 32'(dbg_state), 32'd0);
      #19;
      resetn = 1'b1;

      // request coincident with flush in IDLE is refused
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op1   = 32'd11;
      bus.flush     = 1'b1;
      @(negedge clk);
      check("flush_idle_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      check("flush_idle_busy", 32'(busy), 32'd0);
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;

      // MUL 7*6 -> rd 5, one-cycle writeback
      run_op(3'd0, 5'd5, 32'd7, 32'd6, 0, 2, 0);
      check("mul_op_count", 32'(op_count), 32'd1);
      // DIVU 100/7 with a long writeback stall
      run_op(3'd5, 5'd9, 32'd100, 32'd7, 0, 4, 10);
      // MULH flushed 3 cycles after accept, then MUL 3*3
      run_op(3'd1, 5'd3, 32'h8000_0000, 32'd2, 1, 8, 3);
      run_op(3'd0, 5'd4, 32'd3, 32'd3, 0, 3, 1);
      // flush with cp_ready, then flush in HOLD with wb_ready
      run_op(3'd3, 5'd6, 32'hdead_beef, 32'h1234_5678, 2, 3, 0);
      run_op(3'd2, 5'd7, 32'hffff_fff0, 32'd9, 3, 2, 0);
      check("flush_op_count", 32'(op_count), 32'd3);

      // reset in the middle of a DIV, then back-to-back MULs and a full wrap
      run_op(3'd4, 5'd8, 32'd1000, 32'hffff_fff9, 4, 20, 0);
      run_op(3'd0, 5'd1, 32'd12, 32'd13, 0, 1, 0);
      run_op(3'd0, 5'd2, 32'd65536, 32'd65536, 0, 1, 0);
      for (int i = 0; i < 14; i++) begin
         run_op(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), pick_op(), pick_op(), 0,
                $urandom_range(1, 5), $urandom_range(0, 2));
      end
      check("wrap_op_count", 32'(op_count), 32'd0);

      // randomized mix
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            7: mode = 1;
            8: mode = 2;
            9: mode = 3;
            default: mode = 0;
         endcase
         hold = $urandom_range(0, 3);
         lat  = $urandom_range(1, 5);
         if (mode == 1) begin
            hold = $urandom_range(0, 2);
            lat  = hold + 2 + $urandom_range(0, 3);
         end
         run_op(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), pick_op(), pick_op(), mode,
                lat, hold);
      end

      repeat (3) @(negedge clk);
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
